// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an AXI4-Stream byte port through a small FIFO.
// Frames are 8N1 or 8N2 and leave back-to-back while bytes are queued.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic                        txd,
  output logic                        busy,
  output logic                        frame_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  input  logic [15:0]                 prescale
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic STOP_LAST = (STOP_BITS == 2);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [AW:0] level_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic        stop_q, stop_d;
  logic [18:0] timer_q, timer_d;
  logic [18:0] reload_q, reload_d;
  logic [18:0] start_reload;
  logic [15:0] presc_eff;
  logic [7:0]  head;
  logic        push, load, empty, tick;
  logic        tready_q, tready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        txd_q, txd_d;

  assign empty        = (wptr_q == rptr_q);
  assign push         = s_axis_tvalid && tready_q;
  assign tick         = (timer_q == '0);
  assign head         = mem_q[rptr_q[AW-1:0]];
  assign presc_eff    = (prescale == '0) ? 16'd1 : prescale;
  assign start_reload = {presc_eff, 3'b000} - 19'd1;

  assign wptr_d  = wptr_q + {{AW{1'b0}}, push};
  assign rptr_d  = rptr_q + {{AW{1'b0}}, load};
  assign level_d = wptr_d - rptr_d;

  // Storage carries no reset; pointers alone define the contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= s_axis_tdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      timer_q  <= '0;
      reload_q <= '0;
      tready_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      timer_q  <= timer_d;
      reload_q <= reload_d;
      tready_q <= tready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      txd_q    <= txd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    reload_d = reload_q;
    timer_d  = tick ? reload_q : timer_q - 19'd1;
    load     = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = timer_q;
        load    = !empty;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == 3'd7) begin
            state_d = STOP;
            stop_d  = 1'b0;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_q == STOP_LAST) begin
            done_d  = 1'b1;
            load    = !empty;
            state_d = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
    endcase
    // Next frame starts on the same edge, so prescale is resampled here.
    if (load) begin
      shift_d  = head;
      reload_d = start_reload;
      timer_d  = start_reload;
      state_d  = START;
    end
  end

  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      IDLE:  txd_d = 1'b1;
      START: txd_d = 1'b0;
      DATA:  txd_d = shift_d[0];
      STOP:  txd_d = 1'b1;
    endcase
    busy_d   = (state_d != IDLE) || (level_d != '0);
    tready_d = (level_d != DEPTH_L);
  end

  assign s_axis_tready = tready_q;
  assign txd           = txd_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign fifo_level    = wptr_q - rptr_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based frame model plus directed
// scenarios on an 8N1 instance and an 8N2 instance.
module tb_uart_tx_fifo;

  localparam int DEPTH = 4;
  localparam int NTR   = 16384;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  tdata;
  logic        tvalid, tvalid2;
  logic [15:0] prescale;
  logic        tready, txd, busy, fdone;
  logic [2:0]  level;
  logic        tready2, txd2, busy2, fdone2;
  logic [2:0]  level2;

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .txd(txd), .busy(busy),
    .frame_done(fdone), .fifo_level(level), .prescale(prescale)
  );

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid2),
    .s_axis_tready(tready2), .txd(txd2), .busy(busy2),
    .frame_done(fdone2), .fifo_level(level2), .prescale(prescale)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] mq[$];
  bit   m_ready, m_busy, m_active, m_done;
  int   m_t, m_s, m_end, m_p, m_accepts;
  logic [7:0] m_byte;
  int   e_all, e_first;

  bit tr_txd [NTR];
  bit tr_done[NTR];
  bit tr_busy[NTR];
  int tr_lvl [NTR];
  bit tr_txd2 [NTR];
  bit tr_done2[NTR];
  bit tr_busy2[NTR];

  function automatic bit m_txd();
    int off, b;
    if (!m_active) return 1'b1;
    off = m_t - m_s;
    b = off / (8 * m_p);
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit pu;
    m_t++;
    m_done = 1'b0;
    if (!rst_n) begin
      mq.delete();
      m_active = 1'b0;
      m_ready = 1'b0;
      m_busy = 1'b0;
      return;
    end
    pu = tvalid && m_ready;
    if (m_active && m_t == m_end) begin
      m_done = 1'b1;
      m_active = 1'b0;
    end
    if (!m_active && mq.size() > 0) begin
      m_byte = mq.pop_front();
      m_p = (prescale == 0) ? 1 : int'(prescale);
      m_s = m_t;
      m_end = m_t + 10 * 8 * m_p;
      m_active = 1'b1;
    end
    if (pu) begin
      mq.push_back(tdata);
      m_accepts++;
    end
    m_ready = (mq.size() != DEPTH);
    m_busy = m_active || (mq.size() != 0);
  endtask

  task automatic tick(input bit v, input bit v2, input logic [7:0] d);
    int mism;
    tvalid = v;
    tvalid2 = v2;
    tdata = d;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    if (m_t < NTR) begin
      tr_txd[m_t] = txd;
      tr_done[m_t] = fdone;
      tr_busy[m_t] = busy;
      tr_lvl[m_t] = int'(level);
      tr_txd2[m_t] = txd2;
      tr_done2[m_t] = fdone2;
      tr_busy2[m_t] = busy2;
    end
    mism = 0;
    if (txd !== m_txd()) mism++;
    if (fdone !== m_done) mism++;
    if (level !== 3'(mq.size())) mism++;
    if (tready !== m_ready) mism++;
    if (busy !== m_busy) mism++;
    if (mism != 0) begin
      if (e_all == 0) e_first = m_t;
      e_all += mism;
    end
  endtask

  function automatic logic [7:0] dec1(int s, int p);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[j] = tr_txd[s + 8*p*(j+1) + 4*p];
    return b;
  endfunction

  function automatic int find_done(int from, int to);
    for (int i = from; i <= to; i++) if (tr_done[i]) return i;
    return -1;
  endfunction

  function automatic int count_done(int from, int to);
    int n = 0;
    for (int i = from; i <= to; i++) if (tr_done[i]) n++;
    return n;
  endfunction

  task automatic test_reset();
    e_all = 0;
    rst_n = 1'b0;
    prescale = 16'd1;
    repeat (3) tick(0, 0, 8'h00);
    n_chk++;
    if (txd !== 1'b1) begin
      n_fail++; $display("FAIL reset_txd: got %b want 1", txd);
    end
    n_chk++;
    if (tready !== 1'b0) begin
      n_fail++; $display("FAIL reset_tready: got %b want 0", tready);
    end
    n_chk++;
    if (busy !== 1'b0 || fdone !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_done: got %b%b want 00", busy, fdone);
    end
    n_chk++;
    if (level !== 3'd0) begin
      n_fail++; $display("FAIL reset_level: got %0d want 0", level);
    end
    rst_n = 1'b1;
    tick(0, 0, 8'h00);
    n_chk++;
    if (tready !== 1'b1 || tready2 !== 1'b1) begin
      n_fail++;
      $display("FAIL release_tready: got %b%b want 11", tready, tready2);
    end
    n_chk++;
    if (e_all !== 0) begin
      n_fail++;
      $display("FAIL reset_model: %0d mismatches from edge %0d want 0",
               e_all, e_first);
    end
  endtask

  task automatic test_single_byte();
    int pe, s, hi, fd;
    logic [7:0] got;
    e_all = 0;
    prescale = 16'd1;
    tick(1, 0, 8'h55);
    pe = m_t;
    s = pe + 1;
    repeat (96) tick(0, 0, 8'h00);
    n_chk++;
    if (tr_txd[pe] !== 1'b1 || tr_txd[s] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency: txd %b then %b want 1 then 0",
               tr_txd[pe], tr_txd[s]);
    end
    n_chk++;
    if (tr_txd[s+7] !== 1'b0 || tr_txd[s+8] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_start_len: %b%b want 01",
               tr_txd[s+7], tr_txd[s+8]);
    end
    got = dec1(s, 1);
    n_chk++;
    if (got !== 8'h55) begin
      n_fail++; $display("FAIL single_data: got %h want 55", got);
    end
    hi = 0;
    for (int i = s + 72; i < s + 80; i++) hi += tr_txd[i];
    n_chk++;
    if (hi !== 8) begin
      n_fail++; $display("FAIL single_stop: high %0d want 8", hi);
    end
    fd = find_done(s, s + 95);
    n_chk++;
    if (fd !== s + 80 || tr_done[s+81] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: at offset %0d want 80", fd - s);
    end
    n_chk++;
    if (tr_busy[s+79] !== 1'b1 || tr_busy[s+80] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy: %b%b want 10",
               tr_busy[s+79], tr_busy[s+80]);
    end
    n_chk++;
    if (e_all !== 0) begin
      n_fail++;
      $display("FAIL single_model: %0d mismatches from edge %0d want 0",
               e_all, e_first);
    end
  endtask

  task automatic test_back_to_back();
    int pe, s, peak, nd;
    logic [7:0] exp_b [3];
    logic [7:0] got;
    exp_b = '{8'h90, 8'h3C, 8'h7F};
    e_all = 0;
    prescale = 16'd2;
    tick(1, 0, exp_b[0]);
    pe = m_t;
    s = pe + 1;
    tick(1, 0, exp_b[1]);
    tick(1, 0, exp_b[2]);
    repeat (500) tick(0, 0, 8'h00);
    peak = 0;
    for (int i = pe; i <= pe + 500; i++)
      if (tr_lvl[i] > peak) peak = tr_lvl[i];
    n_chk++;
    if (peak !== 2) begin
      n_fail++; $display("FAIL b2b_peak: got %0d want 2", peak);
    end
    for (int k = 0; k < 3; k++) begin
      got = dec1(s + 160*k, 2);
      n_chk++;
      if (got !== exp_b[k] || tr_txd[s+160*k] !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_byte%0d: got %h want %h", k, got, exp_b[k]);
      end
    end
    nd = count_done(s, s + 499);
    n_chk++;
    if (nd !== 3 || !tr_done[s+160] || !tr_done[s+320]
        || !tr_done[s+480]) begin
      n_fail++;
      $display("FAIL b2b_done: %0d pulses want 3 at 160 spacing", nd);
    end
    n_chk++;
    if (e_all !== 0) begin
      n_fail++;
      $display("FAIL b2b_model: %0d mismatches from edge %0d want 0",
               e_all, e_first);
    end
  endtask

  task automatic test_full_fifo();
    int i, blocked, s1;
    int acc_edge [6];
    bit v, acc;
    logic [7:0] got;
    e_all = 0;
    prescale = 16'd1;
    i = 0;
    blocked = -1;
    for (int c = 0; c < 700; c++) begin
      v = (i < 6);
      if (i > 0 && blocked < 0 && tready === 1'b0) blocked = i;
      acc = v && (tready === 1'b1);
      tick(v, 0, 8'(i + 1));
      if (acc) begin
        acc_edge[i] = m_t;
        i++;
      end
    end
    s1 = acc_edge[0] + 1;
    n_chk++;
    if (blocked !== 5) begin
      n_fail++; $display("FAIL full_accept: got %0d want 5", blocked);
    end
    n_chk++;
    if (i !== 6 || acc_edge[5] !== s1 + 81) begin
      n_fail++;
      $display("FAIL full_sixth: %0d taken, 6th at %0d want %0d",
               i, acc_edge[5], s1 + 81);
    end
    for (int k = 0; k < 6; k++) begin
      got = dec1(s1 + 80*k, 1);
      n_chk++;
      if (got !== 8'(k + 1)) begin
        n_fail++;
        $display("FAIL full_byte%0d: got %h want %h", k, got, 8'(k+1));
      end
    end
    n_chk++;
    if (e_all !== 0) begin
      n_fail++;
      $display("FAIL full_model: %0d mismatches from edge %0d want 0",
               e_all, e_first);
    end
  endtask

  task automatic test_two_stop();
    int pe, s, lo, hi, fd;
    e_all = 0;
    prescale = 16'd1;
    tick(0, 1, 8'hFF);
    pe = m_t;
    s = pe + 1;
    repeat (110) tick(0, 0, 8'h00);
    lo = 0;
    for (int i = s; i < s + 8; i++) lo += (tr_txd2[i] == 1'b0);
    hi = 0;
    for (int i = s + 8; i < s + 96; i++) hi += tr_txd2[i];
    n_chk++;
    if (tr_txd2[pe] !== 1'b1 || lo !== 8) begin
      n_fail++; $display("FAIL stop2_start: low %0d want 8", lo);
    end
    n_chk++;
    if (hi !== 88) begin
      n_fail++; $display("FAIL stop2_high: high %0d want 88", hi);
    end
    fd = -1;
    for (int i = s; i <= s + 100; i++)
      if (fd < 0 && tr_done2[i]) fd = i;
    n_chk++;
    if (fd !== s + 88 || tr_done2[s+89] !== 1'b0) begin
      n_fail++;
      $display("FAIL stop2_done: at offset %0d want 88", fd - s);
    end
    n_chk++;
    if (tr_busy2[s+87] !== 1'b1 || tr_busy2[s+88] !== 1'b0) begin
      n_fail++;
      $display("FAIL stop2_busy: %b%b want 10",
               tr_busy2[s+87], tr_busy2[s+88]);
    end
  endtask

  task automatic test_reset_mid();
    int pe, s, lows, nd;
    e_all = 0;
    prescale = 16'd1;
    tick(1, 0, 8'h00);
    pe = m_t;
    s = pe + 1;
    tick(1, 0, 8'hA1);
    tick(1, 0, 8'hB2);
    while (m_t < s + 35) tick(0, 0, 8'h00);
    n_chk++;
    if (txd !== 1'b0 || level !== 3'd2) begin
      n_fail++;
      $display("FAIL mid_pre: txd %b level %0d want 0 and 2", txd, level);
    end
    rst_n = 1'b0;
    tick(0, 0, 8'h00);
    n_chk++;
    if (txd !== 1'b1 || level !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: txd %b level %0d busy %b want 1 0 0",
               txd, level, busy);
    end
    rst_n = 1'b1;
    lows = 0;
    nd = 0;
    repeat (200) begin
      tick(0, 0, 8'h00);
      lows += (txd == 1'b0);
      nd += (fdone == 1'b1);
    end
    n_chk++;
    if (lows !== 0 || nd !== 0 || tready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_after: lows %0d done %0d tready %b want 0 0 1",
               lows, nd, tready);
    end
    n_chk++;
    if (e_all !== 0) begin
      n_fail++;
      $display("FAIL mid_model: %0d mismatches from edge %0d want 0",
               e_all, e_first);
    end
  endtask

  task automatic test_prescale();
    int pe, s, s2, fd;
    logic [7:0] b0, b1, b2, got;
    e_all = 0;
    b0 = 8'($urandom) | 8'h01;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    prescale = 16'd0;
    tick(1, 0, b0);
    pe = m_t;
    s = pe + 1;
    repeat (86) tick(0, 0, 8'h00);
    n_chk++;
    if (tr_txd[s+7] !== 1'b0 || tr_txd[s+8] !== 1'b1
        || find_done(s, s + 85) !== s + 80) begin
      n_fail++;
      $display("FAIL p0_period: done at offset %0d want 80",
               find_done(s, s + 85) - s);
    end
    got = dec1(s, 1);
    n_chk++;
    if (got !== b0) begin
      n_fail++; $display("FAIL p0_data: got %h want %h", got, b0);
    end
    prescale = 16'd1;
    tick(1, 0, b1);
    s2 = m_t + 1;
    tick(1, 0, b2);
    while (m_t < s2 + 20) tick(0, 0, 8'h00);
    prescale = 16'd3;
    while (m_t < s2 + 340) tick(0, 0, 8'h00);
    n_chk++;
    fd = find_done(s2, s2 + 200);
    if (fd !== s2 + 80) begin
      n_fail++;
      $display("FAIL pchg_frame1: done at offset %0d want 80", fd - s2);
    end
    n_chk++;
    fd = find_done(s2 + 81, s2 + 339);
    if (fd !== s2 + 320) begin
      n_fail++;
      $display("FAIL pchg_frame2: done at offset %0d want 320", fd - s2);
    end
    got = dec1(s2, 1);
    n_chk++;
    if (got !== b1) begin
      n_fail++; $display("FAIL pchg_data1: got %h want %h", got, b1);
    end
    got = dec1(s2 + 80, 3);
    n_chk++;
    if (got !== b2) begin
      n_fail++; $display("FAIL pchg_data2: got %h want %h", got, b2);
    end
    n_chk++;
    if (e_all !== 0) begin
      n_fail++;
      $display("FAIL prescale_model: %0d mismatches from edge %0d want 0",
               e_all, e_first);
    end
  endtask

  task automatic test_random();
    int a0, nd, nacc;
    bit v, acc;
    e_all = 0;
    a0 = m_accepts;
    nd = 0;
    nacc = 0;
    for (int c = 0; c < 3000; c++) begin
      v = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 49) == 0) prescale = 16'($urandom_range(0, 3));
      acc = v && (tready === 1'b1);
      tick(v, 0, 8'($urandom));
      nacc += int'(acc);
      nd += (fdone === 1'b1);
    end
    repeat (1500) begin
      tick(0, 0, 8'h00);
      nd += (fdone === 1'b1);
    end
    n_chk++;
    if (nacc !== m_accepts - a0) begin
      n_fail++;
      $display("FAIL rand_accepts: got %0d want %0d",
               nacc, m_accepts - a0);
    end
    n_chk++;
    if (nd !== m_accepts - a0) begin
      n_fail++;
      $display("FAIL rand_frames: got %0d want %0d", nd, m_accepts - a0);
    end
    n_chk++;
    if (busy !== 1'b0 || level !== 3'd0 || txd !== 1'b1) begin
      n_fail++;
      $display("FAIL rand_drain: busy %b level %0d txd %b want 0 0 1",
               busy, level, txd);
    end
    n_chk++;
    if (e_all !== 0) begin
      n_fail++;
      $display("FAIL rand_model: %0d mismatches from edge %0d want 0",
               e_all, e_first);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    tdata = 8'h00;
    tvalid = 1'b0;
    tvalid2 = 1'b0;
    prescale = 16'd1;
    m_t = 0;
    m_accepts = 0;
    m_ready = 1'b0;
    m_busy = 1'b0;
    m_active = 1'b0;
    m_done = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full_fifo();
    test_two_stop();
    test_reset_mid();
    test_prescale();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- UART transmitter with an AXI4-Stream byte input and an internal FIFO. It is the transmit-side counterpart of the existing UART receiver and uses the same prescale convention.
- It serialises MIDI and other host bytes onto txd as 8N1 frames (or 8N2), sent back-to-back with no idle gap while data is queued.
- The FIFO absorbs bursts (for example, 3-byte MIDI messages) so upstream logic is not stalled per byte.

Parameters:
- FIFO_DEPTH, 4: FIFO entries. Must be a power of two, at least 2.
- STOP_BITS, 1: number of stop bits per frame. Legal values are 1 or 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- s_axis_tdata  in  8  byte to transmit.
- s_axis_tvalid  in  1  source has a byte.
- s_axis_tready  out  1  FIFO can accept a byte.
- txd  out  1  serial output; idle high.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- frame_done  out  1  one-cycle pulse when the final stop bit of a frame completes.
- fifo_level  out  clog2(FIFO_DEPTH)+1  number of bytes queued; excludes the byte currently in the shift register.
- prescale  in  16  bit period = prescale*8 clk cycles. Same units as the receiver.

Behaviour:
- Reset (rst_n low at a clock edge):
  - txd=1, s_axis_tready=0, busy=0, frame_done=0, fifo_level=0.
  - FIFO is flushed; the state machine goes to IDLE.
  - Reset mid-frame aborts the frame immediately: txd is 1 at that edge and the partial byte is discarded.
- After reset release: s_axis_tready = (fifo_level != FIFO_DEPTH), registered. It reads 1 on the first cycle after release.
- Push: on an edge where s_axis_tvalid && s_axis_tready, the byte is written to the FIFO.
- Simultaneous push and pop: fifo_level is unchanged and data order is preserved. The FIFO is strictly first in, first out.
- Prescale sampling:
  - prescale is sampled when a frame starts (IDLE to START) and held for the whole frame.
  - prescale==0 is treated as 1.
  - The bit counter is 19 bits wide and reloads with (p<<3)-1, so the maximum period is 524280 cycles with no overflow.
- State machine states: IDLE, START, DATA, STOP.
- IDLE:
  - txd=1.
  - If the FIFO is non-empty: pop the head into the shift register, load the bit timer, go to START. txd=0 from this edge.
  - Latency: a byte pushed into an empty FIFO while IDLE at edge N gives txd=0 at edge N+1.
- START: txd=0 for one bit period, then go to DATA with bit index 0.
- DATA:
  - Drives shift[0] for one bit period, LSB first, for 8 bits.
  - The shift register moves right at each bit boundary.
  - After bit 7, go to STOP.
- STOP:
  - txd=1 for STOP_BITS bit periods.
  - At the edge ending the last stop period, frame_done pulses for exactly one cycle.
  - If the FIFO is non-empty at that edge: pop, resample prescale, enter START. txd=0 at that same edge, so there is no idle cycle.
  - Otherwise, go to IDLE.
- Frame length is exactly (9+STOP_BITS)*p*8 cycles from the falling edge of the start bit to the end of the stop bits.
- busy = (state != IDLE) || (fifo_level != 0), registered consistently with the state. It drops on the cycle IDLE is entered with an empty FIFO.
- Changing prescale mid-frame has no effect until the next frame start.
- Full FIFO: s_axis_tready=0 and tvalid is ignored. Data is never dropped or overwritten, and the FIFO has no overrun condition.
- Empty FIFO: no pop occurs and txd stays 1.
- Read and write pointers are clog2(FIFO_DEPTH)+1 bits and wrap naturally. Full and empty are distinguished by the pointer MSB.

Test Plan:
- Single byte: prescale=1, push 0x55 while idle. Required: txd=0 one cycle after the push, then bits 1,0,1,0,1,0,1,0 at 8 cycles each, then stop=1 for 8 cycles. frame_done pulses at cycle 80. busy then falls.
- Back-to-back: STOP_BITS=1, prescale=2, push 0x90, 0x3C, 0x7F in consecutive cycles. Required: three frames of 160 cycles each with no gap; the decoded bytes are 0x90, 0x3C, 0x7F; fifo_level peaks at 2; three frame_done pulses occur 160 cycles apart.
- Full FIFO: FIFO_DEPTH=4, prescale=1, tvalid held high with bytes 0x01..0x06. Required: 5 bytes accepted (1 in the shift register, 4 queued), then tready=0. 0x06 is accepted only after the first frame's pop. All 6 bytes are transmitted in order.
- Two stop bits: STOP_BITS=2, prescale=1, byte 0xFF. Required: start 8 cycles, then 88 cycles high, frame_done at cycle 88.
- Reset mid-frame: rst_n low during DATA bit 3 of 0x00 with 2 bytes queued. Required: txd=1 at that edge; fifo_level=0 and busy=0. After release, no further frames are sent and tready=1.
- prescale=0 and a change mid-frame: prescale=0 gives 8-cycle bits. Switching prescale from 1 to 3 mid-frame keeps 8-cycle bits until frame end; the next frame uses 24-cycle bits.
